store_queue: RTL
================

Name: store_queue

Overview:
Circular store buffer immediately downstream of the load/store FU.
- Allocates a slot per store at dispatch and returns its index; the FU later carries this index back as sq_pos.
- Captures the computed address and data when the FU reports completion, and holds stores until ROB retirement.
- Drains retired stores in order to the data-memory port, and serves store-to-load forwarding lookups for loads.

Parameters:
SQ_DEPTH, 8, number of entries (power of two, >=2)
SQ_IDX_LEN, 3, log2(SQ_DEPTH)
XLEN, 32, address/data width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  flush all non-retired entries
alloc_valid  in  1  dispatch allocates one store entry this cycle
alloc_ready  out  1  queue not full (registered count < SQ_DEPTH)
alloc_pos  out  SQ_IDX_LEN  tail index handed to dispatch
fill_valid  in  1  FU store result valid
fill_pos  in  SQ_IDX_LEN  entry to fill
fill_addr  in  XLEN  store address
fill_data  in  XLEN  store data (rs2 value)
fill_size  in  2  0=byte, 1=half, 2=word
retire_valid  in  1  ROB retires the oldest non-retired store
mem_req_valid  out  1  head entry is retired and presented to memory
mem_req_addr  out  XLEN  head address
mem_req_data  out  XLEN  head data
mem_req_size  out  2  head size
mem_req_ready  in  1  memory accepts request
fwd_valid  in  1  load lookup request
fwd_pos  in  SQ_IDX_LEN  tail index captured when the load dispatched; entries before it are older
fwd_addr  in  XLEN  load address
fwd_hit  out  1  forward fwd_data
fwd_data  out  XLEN  forwarded word
fwd_stall  out  1  load must wait
count  out  SQ_IDX_LEN+1  occupied entries

Behaviour:
- Per-entry state: FREE, ALLOC (address unknown), READY (filled), RETIRED.
- Pointers: head, retire_ptr, tail; each carries one wrap bit.
- count = tail - head (mod 2*SQ_DEPTH).
- Reset: all entries FREE; pointers 0; count 0; alloc_ready 1; alloc_pos 0; mem_req_valid 0; fwd_hit 0; fwd_stall 0; data outputs 0.
- Alloc: on alloc_valid && alloc_ready, entry[tail] becomes ALLOC and tail increments.
  - alloc_ready is derived from registered count only; a same-cycle pop does not free a slot for this cycle.
  - alloc_valid with alloc_ready=0 is ignored.
- Fill: on fill_valid, entry[fill_pos] becomes READY and latches addr/data/size.
  - Fill of a FREE or RETIRED entry is ignored (a stale FU result after squash).
  - Filled values are visible to forwarding next cycle.
- Retire: on retire_valid, entry[retire_ptr] becomes RETIRED and retire_ptr increments.
  - Retire of an ALLOC entry is a protocol violation and is flagged by a bench assertion.
  - Fill and retire of the same entry in the same cycle: the entry becomes RETIRED with the filled data.
- Drain: mem_req_valid = (entry[head] == RETIRED), driven from registered state.
  - Earliest request is the cycle after retire.
  - On mem_req_valid && mem_req_ready, entry[head] becomes FREE and head increments.
  - mem_req_* stay stable while valid && !ready.
- Squash: all ALLOC/READY entries become FREE and tail <= retire_ptr in the next cycle.
  - RETIRED entries survive and continue draining.
  - Priority within a squash cycle: retire applies first, so a store retiring in that cycle survives. Alloc and fill that cycle are dropped. A drain pop in the same cycle still completes.
- Forward (combinational, one cycle):
  - Search entries from fwd_pos-1 backward to head; the youngest non-FREE entry whose word address (addr[XLEN-1:2]) matches, or which is ALLOC, decides the result.
  - ALLOC found first -> fwd_stall=1.
  - Matching READY/RETIRED word store -> fwd_hit=1, fwd_data=data.
  - Matching byte/half store -> fwd_stall=1 (no partial merge).
  - No match -> both 0.
  - fwd_valid=0 -> both 0.
  - fwd_pos == head with count 0 -> no older stores.
- Wrap-around: pointer increment modulo SQ_DEPTH with the wrap bit toggled. Full = indices equal and wrap bits differ.

Test Plan:
- Reset, then 8 allocs back-to-back -> alloc_pos 0..7; after the 8th, alloc_ready=0 and count=8; a 9th alloc is ignored.
- Alloc pos0; fill addr 0x100, data 0xDEAD_BEEF, size 2; retire; mem_req_ready=0 for 3 cycles then 1 -> mem_req_valid rises 1 cycle after retire, fields stable, entry freed, count 0.
- Stores to 0x200 (data 0x11) then 0x200 (data 0x22), both filled; load fwd_pos=2, addr 0x200 -> fwd_hit=1, data 0x22. With the younger store unfilled -> fwd_stall=1.
- Byte store to 0x204; load addr 0x204 -> fwd_stall=1. Load addr 0x300 -> hit=0, stall=0.
- 3 allocs, first retired, squash the same cycle as a second retire -> entries 0,1 RETIRED kept, tail=2, count=2; late fill to pos2 ignored.
- Drain-and-refill across wrap: 20 store lifetimes with random mem_req_ready -> memory sees the stores in program order, with no loss or duplicate.

Source files
------------

// File: rtl/store_queue.sv
// Circular store buffer: allocates at dispatch, captures FU results, holds stores until
// retirement, drains them in order to memory and answers store-to-load forwarding lookups.
//
// Per-entry state table:
//   state      | meaning
//   ST_FREE    | slot unused
//   ST_ALLOC   | allocated at dispatch, address not yet known
//   ST_READY   | address/data captured from the FU, not yet retired
//   ST_RETIRED | committed by the ROB, waiting to drain to memory
module store_queue #(
  parameter int SQ_DEPTH   = 8,
  parameter int SQ_IDX_LEN = 3,
  parameter int XLEN       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [SQ_IDX_LEN-1:0] alloc_pos,
  input  logic                  fill_valid,
  input  logic [SQ_IDX_LEN-1:0] fill_pos,
  input  logic [XLEN-1:0]       fill_addr,
  input  logic [XLEN-1:0]       fill_data,
  input  logic [1:0]            fill_size,
  input  logic                  retire_valid,
  output logic                  mem_req_valid,
  output logic [XLEN-1:0]       mem_req_addr,
  output logic [XLEN-1:0]       mem_req_data,
  output logic [1:0]            mem_req_size,
  input  logic                  mem_req_ready,
  input  logic                  fwd_valid,
  input  logic [SQ_IDX_LEN-1:0] fwd_pos,
  input  logic [XLEN-1:0]       fwd_addr,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  fwd_stall,
  output logic [SQ_IDX_LEN:0]   count
);

  localparam int PW = SQ_IDX_LEN + 1;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_ALLOC   = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_RETIRED = 2'd3;

  logic [1:0]      state     [SQ_DEPTH];
  logic [1:0]      state_nxt [SQ_DEPTH];
  logic [XLEN-1:0] addr_q    [SQ_DEPTH];
  logic [XLEN-1:0] data_q    [SQ_DEPTH];
  logic [1:0]      size_q    [SQ_DEPTH];

  logic [PW-1:0] head, retire_ptr, tail, retire_nxt;
  logic [SQ_IDX_LEN-1:0] head_idx, ret_idx, tail_idx;
  logic do_alloc, do_fill, do_retire, do_pop;

  assign head_idx = head[SQ_IDX_LEN-1:0];
  assign ret_idx  = retire_ptr[SQ_IDX_LEN-1:0];
  assign tail_idx = tail[SQ_IDX_LEN-1:0];

  assign count       = tail - head;
  assign alloc_ready = (count < PW'(SQ_DEPTH));
  assign alloc_pos   = tail_idx;

  assign mem_req_valid = (state[head_idx] == ST_RETIRED);
  assign mem_req_addr  = addr_q[head_idx];
  assign mem_req_data  = data_q[head_idx];
  assign mem_req_size  = size_q[head_idx];

  // Squash drops same-cycle alloc/fill; fills of FREE/RETIRED slots are stale FU results.
  assign do_alloc  = alloc_valid && alloc_ready && !squash;
  assign do_fill   = fill_valid && !squash &&
                     (state[fill_pos] == ST_ALLOC || state[fill_pos] == ST_READY);
  assign do_retire = retire_valid && (retire_ptr != tail);
  assign do_pop    = mem_req_valid && mem_req_ready;

  assign retire_nxt = retire_ptr + {{SQ_IDX_LEN{1'b0}}, do_retire};

  always_comb begin
    state_nxt = state;
    if (do_fill)   state_nxt[fill_pos] = ST_READY;
    if (do_retire) state_nxt[ret_idx]  = ST_RETIRED;
    if (do_pop)    state_nxt[head_idx] = ST_FREE;
    if (do_alloc)  state_nxt[tail_idx] = ST_ALLOC;
    if (squash) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (state_nxt[i] == ST_ALLOC || state_nxt[i] == ST_READY) state_nxt[i] = ST_FREE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      retire_ptr <= '0;
      tail       <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        state[i]  <= ST_FREE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      head       <= head + {{SQ_IDX_LEN{1'b0}}, do_pop};
      retire_ptr <= retire_nxt;
      tail       <= squash ? retire_nxt : tail + {{SQ_IDX_LEN{1'b0}}, do_alloc};
      if (do_fill) begin
        addr_q[fill_pos] <= fill_addr;
        data_q[fill_pos] <= fill_data;
        size_q[fill_pos] <= fill_size;
      end
    end
  end

  // Forwarding: scan from fwd_pos-1 back toward head; the first live candidate decides.
  // fwd_pos == head means no older stores unless the queue is completely full.
  logic [SQ_IDX_LEN-1:0] fwd_dist, scan_idx;
  logic [PW-1:0]         span;
  logic                  found;
  logic                  unused_fwd_lo;

  assign unused_fwd_lo = ^fwd_addr[1:0];
  assign fwd_dist      = fwd_pos - head_idx;
  assign span = (fwd_dist != '0)          ? {1'b0, fwd_dist} :
                (count == PW'(SQ_DEPTH)) ? PW'(SQ_DEPTH) : '0;

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    found     = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      scan_idx = fwd_pos - SQ_IDX_LEN'(k + 1);
      if (fwd_valid && !found && (PW'(k) < span) && state[scan_idx] != ST_FREE) begin
        if (state[scan_idx] == ST_ALLOC) begin
          found     = 1'b1;
          fwd_stall = 1'b1;
        end else if (addr_q[scan_idx][XLEN-1:2] == fwd_addr[XLEN-1:2]) begin
          found = 1'b1;
          if (size_q[scan_idx] == 2'd2) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[scan_idx];
          end else begin
            fwd_stall = 1'b1;
          end
        end
      end
    end
  end

endmodule
